pipe_adder: RTL and testbench

Parametrised, pipelined add/subtract unit built from slice-wise ripple-carry stages, with a valid/ready handshake on input and output. It generalises the single-bit full adder to WIDTH bits and splits the carry chain across STAGES register stages to raise clock rate. It adds subtraction, borrow/carry chaining and signed-overflow detection. It sits between operand producers and downstream datapath consumers that apply back-pressure.

---
 rtl/pipe_adder.sv | 133 +++++++++++++
 tb/tb_pipe_adder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - pipelined slice-wise ripple-carry add/subtract unit with valid/ready handshake
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset, flushes every in-flight operation
//   ai, bi     WIDTH-bit operands
//   ci         carry-in (add) or borrow-in (sub)
//   sub        0 = ai + bi + ci, 1 = ai - bi - ci
//   in_valid   operand set present
//   in_ready   operand set accepted this cycle (combinational from out_valid/out_ready)
//   so         WIDTH-bit result
//   co         carry-out of the top slice; on sub, 1 = no borrow
//   ov         two's-complement signed overflow
//   out_valid  so/co/ov hold a valid result
//   out_ready  consumer takes the result this cycle
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ai,
  input  logic [WIDTH-1:0] bi,
  input  logic             ci,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] so,
  output logic             co,
  output logic             ov,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES_SAFE = (STAGES < 1) ? 1 : STAGES;
  localparam int SW          = WIDTH / STAGES_SAFE;
  localparam int LAST        = STAGES_SAFE - 1;

  generate
    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES_SAFE) != 0)) begin : g_bad_cfg
      $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end
  endgenerate

  // Per-stage registers. a_q/b_q are the skew registers carrying operands
  // forward; s_q is the deskew word where finished result slices accumulate.
  logic [WIDTH-1:0] a_q [STAGES_SAFE];
  logic [WIDTH-1:0] b_q [STAGES_SAFE];
  logic [WIDTH-1:0] s_q [STAGES_SAFE];
  logic             c_q [STAGES_SAFE];
  logic             v_q [STAGES_SAFE];
  logic             ov_q;

  // What each stage sees on its input side, and what it will register.
  logic [WIDTH-1:0] st_a [STAGES_SAFE];
  logic [WIDTH-1:0] st_b [STAGES_SAFE];
  logic [WIDTH-1:0] st_s [STAGES_SAFE];
  logic             st_c [STAGES_SAFE];
  logic             st_v [STAGES_SAFE];
  logic [WIDTH-1:0] nx_s [STAGES_SAFE];
  logic             nx_c [STAGES_SAFE];
  logic             nx_ov;
  logic [SW:0]      slice_sum;
  logic             advance;

  // Whole pipeline moves together; a stall freezes bubbles in place too.
  assign advance  = !v_q[LAST] || out_ready;
  assign in_ready = advance;

  always_comb begin
    // Subtraction is A + ~B + ~borrow, folded in before the first slice.
    st_a[0] = ai;
    st_b[0] = bi ^ {WIDTH{sub}};
    st_c[0] = ci ^ sub;
    st_s[0] = '0;
    st_v[0] = in_valid;
    for (int k = 1; k < STAGES_SAFE; k++) begin
      st_a[k] = a_q[k-1];
      st_b[k] = b_q[k-1];
      st_s[k] = s_q[k-1];
      st_c[k] = c_q[k-1];
      st_v[k] = v_q[k-1];
    end

    slice_sum = '0;
    for (int k = 0; k < STAGES_SAFE; k++) begin
      slice_sum = {1'b0, st_a[k][k*SW +: SW]}
                + {1'b0, st_b[k][k*SW +: SW]}
                + {{SW{1'b0}}, st_c[k]};
      nx_s[k]              = st_s[k];
      nx_s[k][k*SW +: SW]  = slice_sum[SW-1:0];
      nx_c[k]              = slice_sum[SW];
    end

    // a ^ b ^ sum at the MSB recovers the carry into the MSB; XOR with the
    // carry out of the MSB gives signed overflow.
    nx_ov = st_a[LAST][WIDTH-1] ^ st_b[LAST][WIDTH-1]
          ^ nx_s[LAST][WIDTH-1] ^ nx_c[LAST];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES_SAFE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ov_q <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES_SAFE; k++) begin
        v_q[k] <= st_v[k];
        // Bubbles only move the valid bit; data registers keep their value.
        if (st_v[k]) begin
          a_q[k] <= st_a[k];
          b_q[k] <= st_b[k];
          s_q[k] <= nx_s[k];
          c_q[k] <= nx_c[k];
        end
      end
      if (st_v[LAST]) begin
        ov_q <= nx_ov;
      end
    end
  end

  assign so        = s_q[LAST];
  assign co        = c_q[LAST];
  assign ov        = ov_q;
  assign out_valid = v_q[LAST];

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder with a behavioural arithmetic model
module tb_pipe_adder;

  localparam int W = 16;
  localparam int S = 4;

  logic          clk;
  logic          rst;
  logic [W-1:0]  ai;
  logic [W-1:0]  bi;
  logic          ci;
  logic          sub;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  so;
  logic          co;
  logic          ov;
  logic          out_valid;
  logic          out_ready;

  int checks = 0;
  int errors = 0;

  logic [17:0] exp_q [$];

  pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .ai        (ai),
    .bi        (bi),
    .ci        (ci),
    .sub       (sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .so        (so),
    .co        (co),
    .ov        (ov),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic, returns {ov, co, so}.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic c, input logic s);
    int          sa;
    int          sb;
    int          r;
    logic [16:0] u;
    logic        cy;
    logic        o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!s) begin
      u  = {1'b0, a} + {1'b0, b} + {16'b0, c};
      cy = u[16];
      r  = sa + sb + int'(c);
    end else begin
      u  = {1'b0, a} - {1'b0, b} - {16'b0, c};
      cy = (int'(a) >= int'(b) + int'(c));
      r  = sa - sb - int'(c);
    end
    o = (r > 32767) || (r < -32768);
    return {o, cy, u[15:0]};
  endfunction

  task automatic set_in(input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic s, input logic r);
    in_valid  = v;
    ai        = a;
    bi        = b;
    ci        = c;
    sub       = s;
    out_ready = r;
  endtask

  task automatic test_reset;
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, so, co, ov} !== 19'd0) begin
      errors++;
      $display("FAIL reset_hold got=%h required=0", {out_valid, so, co, ov});
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got=%b required=1", in_ready);
    end
    @(negedge clk);
    set_in(1'b1, 16'h1234, 16'h0101, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, so} !== {1'b1, 16'h1335}) begin
      errors++;
      $display("FAIL reset_preload got=%h required=%h", {out_valid, so}, {1'b1, 16'h1335});
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, so, co, ov} !== 19'd0) begin
      errors++;
      $display("FAIL reset_async got=%h required=0", {out_valid, so, co, ov});
    end
    @(negedge clk);
    rst = 1'b0;
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async_release_in_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [15:0] ta [5] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0005};
    logic [15:0] tb [5] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0002};
    logic        tc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] te [5] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000},
                           {1'b1, 1'b1, 16'h7FFF}, {1'b0, 1'b0, 16'hFFFF},
                           {1'b0, 1'b1, 16'h0002}};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      set_in(1'b1, ta[i], tb[i], tc[i], ts[i], 1'b1);
      for (int c = 1; c <= 4; c++) begin
        @(negedge clk);
        set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        #1;
        checks++;
        if (out_valid !== (c == 4)) begin
          errors++;
          $display("FAIL directed_%0d_latency cycle=%0d got=%b required=%b", i, c, out_valid, (c == 4));
        end
        if (c == 4) begin
          checks++;
          if ({ov, co, so} !== te[i]) begin
            errors++;
            $display("FAIL directed_%0d_result got=%h required=%h", i, {ov, co, so}, te[i]);
          end
        end
      end
    end
  endtask

  task automatic test_streaming;
    int k = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 8) set_in(1'b1, 16'(c * 4096), 16'(c), 1'b0, 1'b0, 1'b1);
      else       set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (out_valid !== (c >= 4 && c < 12)) begin
        errors++;
        $display("FAIL stream_valid cycle=%0d got=%b required=%b", c, out_valid, (c >= 4 && c < 12));
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (so !== 16'(k * 4096 + k)) begin
          errors++;
          $display("FAIL stream_result_%0d got=%h required=%h", k, so, 16'(k * 4096 + k));
        end
        k++;
      end
    end
    checks++;
    if (k != 8) begin
      errors++;
      $display("FAIL stream_count got=%0d required=8", k);
    end
  endtask

  task automatic test_back_pressure;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        s;
    logic        v;
    logic        r;
    logic [17:0] exp;
    logic [17:0] prev_out = '0;
    logic        stalled_prev = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (cyc >= 5 && cyc < 14) v = 1'b1;
      else if (cyc < 45)        v = ($urandom_range(0, 3) != 0);
      else                      v = 1'b0;
      if (cyc >= 10 && cyc < 13)      r = 1'b0;
      else if (cyc < 25 || cyc >= 45) r = 1'b1;
      else                            r = 1'($urandom_range(0, 1));
      set_in(v, a, b, c, s, r);
      #1;
      if (stalled_prev) begin
        checks++;
        if ({out_valid, ov, co, so} !== {1'b1, prev_out}) begin
          errors++;
          $display("FAIL bp_stable cycle=%0d got=%h required=%h", cyc, {out_valid, ov, co, so}, {1'b1, prev_out});
        end
      end
      checks++;
      if (in_ready !== (!out_valid || r)) begin
        errors++;
        $display("FAIL bp_in_ready cycle=%0d got=%b required=%b", cyc, in_ready, (!out_valid || r));
      end
      if (cyc >= 10 && cyc < 13) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
          errors++;
          $display("FAIL bp_stall cycle=%0d got in_ready=%b out_valid=%b required in_ready=0 out_valid=1", cyc, in_ready, out_valid);
        end
      end
      if (v && in_ready === 1'b1) exp_q.push_back(model(a, b, c, s));
      if (out_valid === 1'b1 && r) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra_result cycle=%0d got=%h required=none", cyc, {ov, co, so});
        end else begin
          exp = exp_q.pop_front();
          if ({ov, co, so} !== exp) begin
            errors++;
            $display("FAIL bp_result cycle=%0d got=%h required=%h", cyc, {ov, co, so}, exp);
          end
        end
      end
      stalled_prev = (out_valid === 1'b1) && !r;
      prev_out     = {ov, co, so};
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain got pending=%0d out_valid=%b required pending=0 out_valid=0", exp_q.size(), out_valid);
    end
  endtask

  task automatic test_bubbles_reset;
    logic [9:0]  pattern = 10'b1001101101;
    logic        vin [18];
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic        s;
    logic        v;
    logic        exp_v;
    logic [17:0] exp;
    exp_q.delete();
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      v = (cyc < 10) ? pattern[cyc] : 1'b0;
      vin[cyc] = v;
      set_in(v, a, b, c, s, 1'b1);
      #1;
      exp_v = (cyc >= 4) ? vin[cyc-4] : 1'b0;
      checks++;
      if (out_valid !== exp_v) begin
        errors++;
        $display("FAIL bubble_valid cycle=%0d got=%b required=%b", cyc, out_valid, exp_v);
      end
      if (v && in_ready === 1'b1) exp_q.push_back(model(a, b, c, s));
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bubble_extra_result cycle=%0d got=%h required=none", cyc, {ov, co, so});
        end else begin
          exp = exp_q.pop_front();
          if ({ov, co, so} !== exp) begin
            errors++;
            $display("FAIL bubble_result cycle=%0d got=%h required=%h", cyc, {ov, co, so}, exp);
          end
        end
      end
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_in(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1);
    end
    @(negedge clk);
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_during_reset got=%b required=0", out_valid);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_no_valid cycle=%0d got=%b required=0", i, out_valid);
      end
    end

    @(negedge clk);
    a = 16'($urandom);
    b = 16'($urandom);
    c = 1'($urandom_range(0, 1));
    s = 1'($urandom_range(0, 1));
    exp = model(a, b, c, s);
    set_in(1'b1, a, b, c, s, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      #1;
      checks++;
      if (out_valid !== (k == 4)) begin
        errors++;
        $display("FAIL post_reset_latency cycle=%0d got=%b required=%b", k, out_valid, (k == 4));
      end
      if (k == 4) begin
        checks++;
        if ({ov, co, so} !== exp) begin
          errors++;
          $display("FAIL post_reset_result got=%h required=%h", {ov, co, so}, exp);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    test_reset();
    test_directed();
    test_streaming();
    test_back_pressure();
    test_bubbles_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
